// File: rtl/pov_column_scheduler.sv
// Hall-synchronous column scheduler for the POV globe: measures spin period,
// slices each revolution into COLUMNS slots and requests one frame per slot.
module pov_column_scheduler #(
  parameter int SYSTEM_CLOCK   = 50_000_000,
  parameter int AMOUNT_LEDS    = 36,
  parameter int COLUMNS        = 64,
  parameter int PERIOD_WIDTH   = 26,
  parameter int MIN_GAP        = 50_000,
  parameter int TIMEOUT        = 50_000_000,
  parameter int ROM_ADDR_WIDTH = 12
) (
  input  logic                       CLOCK_50,
  input  logic                       KEY0,
  input  logic                       hall_n,
  input  logic                       frame_ack,
  output logic                       frame_req,
  output logic [$clog2(COLUMNS)-1:0] column,
  output logic [ROM_ADDR_WIDTH-1:0]  rom_base,
  output logic [PERIOD_WIDTH-1:0]    period,
  output logic                       period_valid,
  output logic [7:0]                 overrun_count
);

  localparam int COLW = $clog2(COLUMNS);
  localparam int GAPW = $clog2(MIN_GAP + 1);
  localparam int PW   = PERIOD_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    RUN     = 2'd2
  } state_e;

  wire unused_clk_hz = (SYSTEM_CLOCK != 0);

  state_e state_q, state_d;

  logic            hs1_q, hs2_q, hprev_q;
  logic [GAPW-1:0] gap_q;
  logic [PW-1:0]   rev_q;
  logic [PW-1:0]   period_q;
  logic [PW-1:0]   ivl_q;
  logic [PW-1:0]   slot_q;
  logic [COLW-1:0] ncol_q;
  logic            req_q;
  logic [COLW-1:0] col_q;
  logic [ROM_ADDR_WIDTH-1:0] rom_q;
  logic [7:0]      ovr_q;

  logic            fall, acc, tmo;
  logic [PW-1:0]   per_new, ivl_new;
  logic            latch, last, expire, tick;
  logic [COLW-1:0] tick_col;
  logic [ROM_ADDR_WIDTH-1:0] rom_d;

  assign fall    = hprev_q & ~hs2_q;
  assign acc     = fall && (gap_q >= GAPW'(MIN_GAP));
  assign tmo     = (rev_q == PW'(TIMEOUT));
  assign per_new = rev_q + PW'(1);

  always_comb begin
    ivl_new = per_new >> COLW;
    if (ivl_new == '0) ivl_new = PW'(1);
  end

  // state register
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state: an accepted edge beats the timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (acc) state_d = ACQUIRE;
      ACQUIRE, RUN: begin
        if (acc)      state_d = RUN;
        else if (tmo) state_d = IDLE;
      end
      default:      state_d = IDLE;
    endcase
  end

  // outputs / slot ticks
  always_comb begin
    period_valid = (state_q == RUN);
    latch        = acc && (state_q != IDLE);
    last         = (ncol_q == COLW'(COLUMNS - 1));
    expire       = (state_q == RUN) && !last && !tmo
                   && (slot_q == ivl_q - PW'(1));
    tick         = latch || expire;
    tick_col     = latch ? '0 : ncol_q + COLW'(1);
    rom_d        = ROM_ADDR_WIDTH'(32'(tick_col) * AMOUNT_LEDS);
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      hs1_q   <= 1'b1;
      hs2_q   <= 1'b1;
      hprev_q <= 1'b1;
      gap_q   <= '0;
      rev_q   <= '0;
    end else begin
      hs1_q   <= hall_n;
      hs2_q   <= hs1_q;
      hprev_q <= hs2_q;
      if (acc)                         gap_q <= '0;
      else if (gap_q < GAPW'(MIN_GAP)) gap_q <= gap_q + GAPW'(1);
      if (acc)      rev_q <= '0;
      else if (!tmo) rev_q <= rev_q + PW'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      period_q <= '0;
      ivl_q    <= '0;
      slot_q   <= '0;
      ncol_q   <= '0;
    end else begin
      if (latch) begin
        period_q <= per_new;
        ivl_q    <= ivl_new;
        slot_q   <= '0;
        ncol_q   <= '0;
      end else if (expire) begin
        slot_q   <= '0;
        ncol_q   <= ncol_q + COLW'(1);
      end else if (state_q == RUN && !last) begin
        slot_q   <= slot_q + PW'(1);
      end
    end
  end

  // a tick that finds an unacked request is dropped and counted
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      req_q <= 1'b0;
      col_q <= '0;
      rom_q <= '0;
      ovr_q <= '0;
    end else if (tick) begin
      if (!req_q || frame_ack) begin
        req_q <= 1'b1;
        col_q <= tick_col;
        rom_q <= rom_d;
      end else if (ovr_q != 8'hFF) begin
        ovr_q <= ovr_q + 8'd1;
      end
    end else if (req_q && frame_ack) begin
      req_q <= 1'b0;
    end
  end

  assign frame_req     = req_q;
  assign column        = col_q;
  assign rom_base      = rom_q;
  assign period        = period_q;
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_pov_column_scheduler.sv
// Scoreboard bench for pov_column_scheduler: expected requests (column,
// rom_base, cycle) are queued as hall edges are driven and popped on output.
module tb_pov_column_scheduler;

  localparam int COLS = 4;
  localparam int LEDS = 36;

  typedef struct {
    int col;
    int rom;
    int cyc;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hall_n = 1'b1;
  logic        ack = 1'b1;
  logic        req;
  logic [1:0]  col;
  logic [11:0] rom;
  logic [25:0] per;
  logic        pvalid;
  logic [7:0]  ovr;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  req_t sb[$];

  logic       p_req = 1'b0;
  logic       p_ack = 1'b0;
  logic [1:0] p_col = '0;

  pov_column_scheduler #(
    .AMOUNT_LEDS(LEDS),
    .COLUMNS(COLS),
    .PERIOD_WIDTH(26),
    .MIN_GAP(8),
    .TIMEOUT(4096),
    .ROM_ADDR_WIDTH(12)
  ) dut (
    .CLOCK_50(clk),
    .KEY0(rst_n),
    .hall_n(hall_n),
    .frame_ack(ack),
    .frame_req(req),
    .column(col),
    .rom_base(rom),
    .period(per),
    .period_valid(pvalid),
    .overrun_count(ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hall_low(output int n);
    hall_n = 1'b0;
    n = cyc;
  endtask

  task automatic push(input int c, input int at);
    req_t e;
    e.col = c;
    e.rom = c * LEDS;
    e.cyc = at;
    sb.push_back(e);
  endtask

  // monitor: new request => pop and compare; held request => column stable
  always @(negedge clk) begin
    if (rst_n) begin
      if (req && !(p_req && !p_ack)) begin
        if (sb.size() == 0) begin
          chk("spurious_req", 32'(col), 32'hFFFF_FFFF);
        end else begin
          req_t e;
          e = sb.pop_front();
          chk("req_col", 32'(col), 32'(e.col));
          chk("req_rom", 32'(rom), 32'(e.rom));
          chk("req_cyc", 32'(cyc), 32'(e.cyc));
        end
      end else if (req && p_req && !p_ack) begin
        chk("col_hold", 32'(col), 32'(p_col));
      end
    end
    p_req = req;
    p_ack = ack;
    p_col = col;
  end

  initial begin
    int e0, e1, e2, e3, e4, e5, e6, e7, e8;

    #2;
    chk("rst_req", 32'(req), 0);
    chk("rst_valid", 32'(pvalid), 0);
    chk("rst_period", 32'(per), 0);
    chk("rst_ovr", 32'(ovr), 0);
    goto(5);
    rst_n = 1'b1;

    // two accepted edges 400 apart, bounce on the second
    goto(20);
    hall_low(e0);
    goto(e0 + 20);
    hall_n = 1'b1;
    chk("acq_valid", 32'(pvalid), 0);
    goto(e0 + 400);
    hall_low(e1);
    for (int k = 0; k < 4; k++) push(k, e1 + 3 + 100 * k);
    goto(e1 + 3);
    hall_n = 1'b1;
    goto(e1 + 5);
    hall_n = 1'b0;
    goto(e1 + 20);
    hall_n = 1'b1;
    goto(e1 + 30);
    chk("period_400", 32'(per), 400);
    chk("valid_run", 32'(pvalid), 1);

    // ack held low 250 cycles: two ticks dropped
    goto(e1 + 400);
    hall_low(e2);
    ack = 1'b0;
    push(0, e2 + 3);
    push(3, e2 + 303);
    goto(e2 + 20);
    hall_n = 1'b1;
    goto(e2 + 253);
    ack = 1'b1;
    goto(e2 + 260);
    chk("overrun_2", 32'(ovr), 2);
    chk("period_bounce", 32'(per), 400);

    // early edge lands on the column-3 slot expiry
    goto(e2 + 400);
    hall_low(e3);
    for (int k = 0; k < 3; k++) push(k, e3 + 3 + 100 * k);
    goto(e3 + 20);
    hall_n = 1'b1;
    goto(e3 + 300);
    hall_low(e4);
    for (int k = 0; k < 4; k++) push(k, e4 + 3 + 75 * k);
    goto(e4 + 20);
    hall_n = 1'b1;
    goto(e4 + 30);
    chk("period_300", 32'(per), 300);

    // stop: timeout back to IDLE
    goto(e4 + 4090);
    chk("valid_pre_tmo", 32'(pvalid), 1);
    goto(e4 + 4110);
    chk("valid_tmo", 32'(pvalid), 0);
    chk("period_kept", 32'(per), 300);
    chk("req_tmo", 32'(req), 0);

    // reset mid-run with a pending request
    goto(e4 + 4200);
    hall_low(e5);
    goto(e5 + 20);
    hall_n = 1'b1;
    goto(e5 + 400);
    hall_low(e6);
    ack = 1'b0;
    push(0, e6 + 3);
    goto(e6 + 20);
    hall_n = 1'b1;
    goto(e6 + 50);
    chk("held_req", 32'(req), 1);
    rst_n = 1'b0;
    #2;
    chk("arst_req", 32'(req), 0);
    chk("arst_valid", 32'(pvalid), 0);
    chk("arst_period", 32'(per), 0);
    chk("arst_col", 32'(col), 0);
    chk("arst_rom", 32'(rom), 0);
    chk("arst_ovr", 32'(ovr), 0);
    goto(e6 + 55);
    rst_n = 1'b1;
    ack = 1'b1;

    // one edge only arms; the second starts a revolution
    goto(e6 + 80);
    hall_low(e7);
    goto(e7 + 20);
    hall_n = 1'b1;
    goto(e7 + 400);
    hall_low(e8);
    for (int k = 0; k < 4; k++) push(k, e8 + 3 + 100 * k);
    goto(e8 + 20);
    hall_n = 1'b1;
    goto(e8 + 320);
    chk("period_rst", 32'(per), 400);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
